arbitro_mux_16b4x1: RTL and testbench
=====================================

Name: arbitro_mux_16b4x1

Overview:
- Round-robin arbiter that shares the 16-bit 4:1 multiplexer between four requesters.
- Drives the mux select code (Seleccion) and a one-hot grant vector.
- Enforces a per-grant burst limit so no requester can monopolise the shared bus.
- Sits directly in front of the 4:1 mux; Seleccion connects straight to the mux select input.

Parameters:
- MAX_RAFAGA, 4: maximum consecutive cycles one requester keeps the grant while others wait. Legal range 1..15.
- ANCHO_CONT, 4: width of the burst counter. Must satisfy 2^ANCHO_CONT > MAX_RAFAGA.

Ports:
- Clk  input  1: single clock, rising edge.
- Reset  input  1: synchronous, active-high reset.
- Solicitud  input  4: request vector; bit i = requester i (i=0 ↔ TuplaA … i=3 ↔ TuplaD).
- Concesion  output  4: registered one-hot grant; all-zero when idle.
- Seleccion  output  2: registered mux select; equals index of granted requester.
- Valido  output  1: registered; high when any grant is active.
- Cambio  output  1: registered one-cycle pulse when ownership changes (new grant or handover).

Behaviour:
- Reset (sampled at a rising edge while Reset=1): Concesion=0000, Seleccion=00, Valido=0, Cambio=0, burst counter=0, round-robin pointer Ultimo=3 (so requester 0 wins first).
- Reset has priority over all other events, including mid-grant; the grant is dropped on that edge.
- All outputs are registered. Latency from request sampled at edge N to grant visible is 1 cycle (valid after edge N).
- Round-robin search: candidates examined in order Ultimo+1, Ultimo+2, … mod 4. The first one with Solicitud=1 wins. Ultimo updates to the winner.
- State LIBRE (Valido=0):
  - Solicitud=0000 → stay LIBRE; Seleccion holds its last value; Cambio=0.
  - Any bit set → go CONCEDIDO; Concesion=onehot(winner), Seleccion=winner, counter=1, Cambio=1.
- State CONCEDIDO, owner g:
  - Solicitud[g]=0, others pending → hand over on the same edge to the RR winner from g+1. No idle cycle. Counter=1, Cambio=1.
  - Solicitud[g]=0, no others pending → LIBRE; Concesion=0000, Valido=0, Cambio=0, Seleccion holds g.
  - Solicitud[g]=1 and counter<MAX_RAFAGA → keep grant; counter+1; Cambio=0.
  - Solicitud[g]=1, counter==MAX_RAFAGA, another pending → preempt to RR winner from g+1; counter=1; Cambio=1.
  - Solicitud[g]=1, counter==MAX_RAFAGA, none pending → keep grant; counter saturates at MAX_RAFAGA; Cambio=0.
- Simultaneous requests: resolved purely by RR order. Solicitud changes during a cycle affect only the next edge.
- Invariants, every cycle:
  - Concesion is one-hot or zero.
  - Valido == |Concesion.
  - When Valido=1, Concesion[Seleccion]=1.
- MAX_RAFAGA=1 is legal: owner alternates every cycle whenever others are pending.

Optional Feature:
- Macro ARBITRO_PRIORIDAD_FIJA_EN.
- Defined: round-robin pointer is ignored. Every search (from LIBRE, on release, on preemption) picks the lowest pending index, excluding the current owner on preemption. Burst limit still applies, so requester 3 waits while any lower index keeps requesting.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then Solicitud=0000 for 3 cycles → Concesion=0000, Seleccion=00, Valido=0, Cambio=0 throughout.
- Solicitud=0101 held, MAX_RAFAGA=4 → owner 0 for 4 cycles, then 2 for 4, then 0. Seleccion 00,00,00,00,10,10,10,10,00. Cambio pulses at each switch.
- Grant 1 active, Solicitud goes 0010→1000 in one cycle → next edge Concesion=1000, Seleccion=11, Cambio=1, no idle cycle.
- Solicitud=0100 held alone for 10 cycles → Concesion=0100 constant, Cambio=1 only on the first cycle, counter saturated at 4.
- Reset asserted while grant 3 active with Solicitud=1111 → next edge all outputs at reset values. After release, first grant goes to requester 0.
- With ARBITRO_PRIORIDAD_FIJA_EN, Solicitud=1111 held → owners 0, then 1 (preempt after 4), then 0; requester 3 never granted while 0 and 1 persist.

Source files
------------

// File: rtl/arbitro_mux_16b4x1.sv
// Round-robin arbiter driving the select of the shared 16-bit 4:1 mux, with a per-grant burst limit.
// Define ARBITRO_PRIORIDAD_FIJA_EN for lowest-index-first selection instead of round-robin.
module arbitro_mux_16b4x1 #(
    parameter int unsigned MAX_RAFAGA = 4,
    parameter int unsigned ANCHO_CONT = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Solicitud,
    output logic [3:0] Concesion,
    output logic [1:0] Seleccion,
    output logic       Valido,
    output logic       Cambio
);

    typedef enum logic {
        LIBRE,
        CONCEDIDO
    } estado_t;

    localparam logic [ANCHO_CONT-1:0] LIMITE = ANCHO_CONT'(MAX_RAFAGA);

    estado_t               estado;
    logic [ANCHO_CONT-1:0] contador;
    logic [3:0]            candidatos;
    logic                  hallado;
    logic [1:0]            ganador;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
    logic [1:0]            ultimo;
    logic [1:0]            indice;
`endif

    // The current owner is never a candidate: on release its bit is already clear,
    // on preemption it must be skipped. Scanning from lowest to highest priority
    // lets the last hit win.
    always_comb begin
        candidatos = Solicitud;
        if (estado == CONCEDIDO) candidatos[Seleccion] = 1'b0;
        hallado = 1'b0;
        ganador = '0;
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
        for (int unsigned i = 4; i > 0; i--) begin
            if (candidatos[i-1]) begin
                hallado = 1'b1;
                ganador = 2'(i - 1);
            end
        end
`else
        indice = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            indice = ultimo + 2'(i);
            if (candidatos[indice]) begin
                hallado = 1'b1;
                ganador = indice;
            end
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado    <= LIBRE;
            Concesion <= '0;
            Seleccion <= '0;
            Valido    <= 1'b0;
            Cambio    <= 1'b0;
            contador  <= '0;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
            ultimo    <= 2'd3;
`endif
        end else begin
            Cambio <= 1'b0;
            if ((estado == LIBRE && hallado) ||
                (estado == CONCEDIDO && !Solicitud[Seleccion] && hallado) ||
                (estado == CONCEDIDO && Solicitud[Seleccion] && contador >= LIMITE && hallado)) begin
                estado    <= CONCEDIDO;
                Concesion <= 4'b0001 << ganador;
                Seleccion <= ganador;
                Valido    <= 1'b1;
                Cambio    <= 1'b1;
                contador  <= ANCHO_CONT'(1);
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
                ultimo    <= ganador;
`endif
            end else if (estado == CONCEDIDO && !Solicitud[Seleccion]) begin
                estado    <= LIBRE;
                Concesion <= '0;
                Valido    <= 1'b0;
                contador  <= '0;
            end else if (estado == CONCEDIDO && contador < LIMITE) begin
                contador  <= contador + ANCHO_CONT'(1);
            end
            // Remaining cases (idle with no request, saturated with nobody waiting) hold state.
        end
    end

endmodule

// File: tb/tb_arbitro_mux_16b4x1.sv
// Self-checking bench for arbitro_mux_16b4x1: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural arbiter model.
module tb_arbitro_mux_16b4x1;

    localparam int MAX_RAFAGA = 4;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] Solicitud = '0;
    logic [3:0] Concesion;
    logic [1:0] Seleccion;
    logic       Valido;
    logic       Cambio;

    int passed = 0;
    int total  = 0;

    // model state: owner index or -1 when idle
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = 3;
    int m_sel   = 0;
    bit m_cambio = 1'b0;

    arbitro_mux_16b4x1 #(.MAX_RAFAGA(MAX_RAFAGA), .ANCHO_CONT(4)) dut (
        .Clk(Clk), .Reset(Reset), .Solicitud(Solicitud),
        .Concesion(Concesion), .Seleccion(Seleccion), .Valido(Valido), .Cambio(Cambio)
    );

    always #5 Clk = ~Clk;

    function automatic int pick(input logic [3:0] req, input int excl, input int from);
        int i;
        for (int k = 0; k < 4; k++) begin
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
            i = k;
`else
            i = (from + k) % 4;
`endif
            if (i != excl && req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_owner  = w;
        m_sel    = w;
        m_cnt    = 1;
        m_last   = w;
        m_cambio = 1'b1;
    endtask

    task automatic model_step(input logic rst, input logic [3:0] req);
        int w;
        m_cambio = 1'b0;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_last = 3; m_sel = 0;
        end else if (m_owner < 0) begin
            w = pick(req, -1, m_last + 1);
            if (w >= 0) model_grant(w);
        end else if (!req[m_owner]) begin
            w = pick(req, m_owner, m_owner + 1);
            if (w >= 0) model_grant(w);
            else begin m_owner = -1; m_cnt = 0; end
        end else if (m_cnt < MAX_RAFAGA) begin
            m_cnt++;
        end else begin
            w = pick(req, m_owner, m_owner + 1);
            if (w >= 0) model_grant(w);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e_conc;
        logic [1:0] e_sel;
        logic       e_val;
        e_conc = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e_sel  = 2'(m_sel);
        e_val  = (m_owner >= 0);
        total++;
        assert (Concesion === e_conc) passed++;
        else $error("FAIL %s Concesion obs=%b exp=%b", tag, Concesion, e_conc);
        total++;
        assert (Seleccion === e_sel) passed++;
        else $error("FAIL %s Seleccion obs=%b exp=%b", tag, Seleccion, e_sel);
        total++;
        assert (Valido === e_val) passed++;
        else $error("FAIL %s Valido obs=%b exp=%b", tag, Valido, e_val);
        total++;
        assert (Cambio === m_cambio) passed++;
        else $error("FAIL %s Cambio obs=%b exp=%b", tag, Cambio, m_cambio);
        total++;
        assert ((Valido === |Concesion) && $onehot0(Concesion) &&
                (!Valido || Concesion[Seleccion] === 1'b1)) passed++;
        else $error("FAIL %s invariant obs=%b/%b/%b exp=onehot0,consistent", tag, Concesion, Seleccion, Valido);
    endtask

    task automatic step(input logic rst, input logic [3:0] req, input string tag);
        @(negedge Clk);
        Reset = rst;
        Solicitud = req;
        @(posedge Clk);
        #1;
        model_step(rst, req);
        check_outputs(tag);
    endtask

    initial begin
        logic [3:0] r;
        // reset and idle
        step(1'b1, 4'b0000, "reset");
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, "idle");
        // two requesters alternate on burst limit
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0101, "burst_0101");
        step(1'b0, 4'b0000, "release");
        // handover without idle cycle
        step(1'b1, 4'b0000, "reset2");
        step(1'b0, 4'b0010, "grant1");
        step(1'b0, 4'b0010, "grant1_hold");
        step(1'b0, 4'b1000, "handover");
        step(1'b0, 4'b0000, "release3");
        // lone requester saturates, then is preempted right away
        for (int i = 0; i < 10; i++) step(1'b0, 4'b0100, "alone_2");
        step(1'b0, 4'b0101, "preempt_sat");
        step(1'b0, 4'b0000, "release_all");
        // reset in the middle of grant to requester 3
        step(1'b1, 4'b0000, "reset3");
        for (int i = 0; i < 14; i++) step(1'b0, 4'b1111, "all_req");
        step(1'b1, 4'b1111, "reset_mid");
        step(1'b0, 4'b1111, "after_reset");
        // random traffic with sparse resets
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            step(($urandom_range(0, 49) == 0), r, "random");
        end
        // long random holds to exercise burst limits
        for (int i = 0; i < 40; i++) begin
            r = 4'($urandom);
            for (int j = 0; j < 7; j++) step(1'b0, r, "hold");
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
